ddr_port_arbiter: RTL and testbench

//   Shares the single ddr_ctrl block port between the instruction-cache refill path and
//   the data-cache refill/write-back path of cache_manage_unit.

---
 rtl/ddr_port_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
// Shares the single ddr_ctrl block port between the instruction-cache refill
// path and the data-cache refill/write-back path. One 256-bit block
// transaction is in flight at a time. Requests are arbitrated fairly on
// contention. Every output comes straight from a register.
module ddr_port_arbiter #(
   parameter int ADDR_W  = 30,
   parameter int BLOCK_W = 256,
   parameter int TO_CYC  = 4095,
   parameter int TO_W    = 12
) (
   input  logic               clk,
   input  logic               rst,
   // instruction-cache refill port (read only)
   input  logic               ic_req,
   input  logic [ADDR_W-1:0]  ic_addr,
   output logic               ic_ack,
   // data-cache refill / write-back port
   input  logic               dc_req,
   input  logic               dc_write,
   input  logic [ADDR_W-1:0]  dc_addr,
   input  logic [BLOCK_W-1:0] dc_wdata,
   output logic               dc_ack,
   // shared read data returned to the owner
   output logic [BLOCK_W-1:0] rdata,
   // ddr_ctrl block port
   output logic               ram_en,
   output logic               ram_write,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [BLOCK_W-1:0] data_to_ram,
   input  logic               ram_rdy,
   input  logic [BLOCK_W-1:0] block_from_ram,
   // status
   output logic               busy,
   output logic               timeout_err
);

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CYC);
   localparam logic [TO_W-1:0] WD_ONE = {{(TO_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_grant;
   logic                 w_grant_dc;
   logic                 w_done;

   // r_last_dc doubles as the owner of the current transaction, because the
   // last owner is updated at every grant.
   logic                 r_last_dc;

   logic                 r_ram_en;
   logic                 r_ram_write;
   logic [ADDR_W-1:0]    r_ram_addr;
   logic [BLOCK_W-1:0]   r_data_to_ram;
   logic [BLOCK_W-1:0]   r_rdata;
   logic                 r_ic_ack;
   logic                 r_dc_ack;
   logic                 r_busy;
   logic                 r_timeout;
   logic [TO_W-1:0]      r_wdog;
   logic [TO_W-1:0]      w_wdog_inc;

   // Watchdog increment that stops at the limit instead of wrapping.
   function automatic logic [TO_W-1:0] wdog_sat_inc(input logic [TO_W-1:0] cnt);
      if (cnt >= TO_LIM) begin
         return cnt;
      end
      return cnt + WD_ONE;
   endfunction

   // True when the count has reached the limit. A limit of 0 disables the check.
   function automatic logic wdog_expired(input logic [TO_W-1:0] cnt);
      return (TO_CYC != 0) && (cnt == TO_LIM);
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic, arbitration and completion detect
   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_grant_dc   = 1'b0;
      w_done       = (r_state == S_BUSY) && ram_rdy;
      case (r_state)
         S_IDLE: begin
            if (ic_req || dc_req) begin
               w_grant      = 1'b1;
               // On contention, grant the side that did not own the port last.
               w_grant_dc   = dc_req && (!ic_req || !r_last_dc);
               w_state_next = S_BUSY;
            end
         end
         S_BUSY: begin
            if (ram_rdy) begin
               w_state_next = S_ACK;
            end
         end
         S_ACK:   w_state_next = S_GAP;
         S_GAP:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Control outputs, owner acks and the last-owner record
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_en  <= 1'b0;
         r_busy    <= 1'b0;
         r_ic_ack  <= 1'b0;
         r_dc_ack  <= 1'b0;
         r_last_dc <= 1'b0;
      end else begin
         r_ram_en <= (w_state_next == S_BUSY);
         r_busy   <= (w_state_next != S_IDLE);
         r_ic_ack <= w_done && !r_last_dc;
         r_dc_ack <= w_done && r_last_dc;
         if (w_grant) begin
            r_last_dc <= w_grant_dc;
         end
      end
   end

   // Transaction attributes are captured at grant and held until the next grant,
   // so requester changes while the transaction is in flight have no effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ram_write   <= 1'b0;
         r_ram_addr    <= '0;
         r_data_to_ram <= '0;
      end else if (w_grant) begin
         if (w_grant_dc) begin
            r_ram_write   <= dc_write;
            r_ram_addr    <= dc_addr;
            r_data_to_ram <= dc_wdata;
         end else begin
            r_ram_write   <= 1'b0;
            r_ram_addr    <= ic_addr;
         end
      end
   end

   // Read data is captured only when a read completes. Writes leave it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_done && !r_ram_write) begin
         r_rdata <= block_from_ram;
      end
   end

   // Saturating watchdog sampled every clock
   always_comb begin
      w_wdog_inc = wdog_sat_inc(r_wdog);
   end

   // Watchdog counts BUSY cycles and raises a sticky error.
   // The transaction keeps running after the error is raised.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         if ((r_state == S_BUSY) && !ram_rdy) begin
            r_wdog <= w_wdog_inc;
         end else begin
            r_wdog <= '0;
         end
         if ((r_state == S_BUSY) && wdog_expired(w_wdog_inc)) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign ram_en      = r_ram_en;
   assign ram_write   = r_ram_write;
   assign ram_addr    = r_ram_addr;
   assign data_to_ram = r_data_to_ram;
   assign rdata       = r_rdata;
   assign ic_ack      = r_ic_ack;
   assign dc_ack      = r_dc_ack;
   assign busy        = r_busy;
   assign timeout_err = r_timeout;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Testbench for ddr_port_arbiter: scoreboard of expected DDR transactions and
// a DDR responder that checks each granted transaction against it.
module tb_ddr_port_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ic_req = 1'b0;
   logic [29:0]  ic_addr = '0;
   logic         ic_ack;
   logic         dc_req = 1'b0;
   logic         dc_write = 1'b0;
   logic [29:0]  dc_addr = '0;
   logic [255:0] dc_wdata = '0;
   logic         dc_ack;
   logic [255:0] rdata;
   logic         ram_en;
   logic         ram_write;
   logic [29:0]  ram_addr;
   logic [255:0] data_to_ram;
   logic         ram_rdy = 1'b0;
   logic [255:0] block_from_ram = '0;
   logic         busy;
   logic         timeout_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_rdy_edge = 0;
   logic [255:0] model_rdata = '0;

   typedef struct {
      bit           is_dc;
      bit           wr;
      logic [29:0]  addr;
      logic [255:0] wdata;
      logic [255:0] blk;
   } txn_t;

   txn_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ddr_port_arbiter #(
      .ADDR_W  (30),
      .BLOCK_W (256),
      .TO_CYC  (8),
      .TO_W    (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ic_req         (ic_req),
      .ic_addr        (ic_addr),
      .ic_ack         (ic_ack),
      .dc_req         (dc_req),
      .dc_write       (dc_write),
      .dc_addr        (dc_addr),
      .dc_wdata       (dc_wdata),
      .dc_ack         (dc_ack),
      .rdata          (rdata),
      .ram_en         (ram_en),
      .ram_write      (ram_write),
      .ram_addr       (ram_addr),
      .data_to_ram    (data_to_ram),
      .ram_rdy        (ram_rdy),
      .block_from_ram (block_from_ram),
      .busy           (busy),
      .timeout_err    (timeout_err)
   );

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic txn_t mk(input bit is_dc, input bit wr, input logic [29:0] addr,
                               input logic [255:0] wdata, input logic [255:0] blk);
      txn_t t;
      t.is_dc = is_dc;
      t.wr    = wr;
      t.addr  = addr;
      t.wdata = wdata;
      t.blk   = blk;
      return t;
   endfunction

   // DDR responder: waits for a grant, checks it against the scoreboard head,
   // holds ram_rdy off for lat cycles of ram_en, then checks the ack.
   // to_at > 0: timeout_err must be 1 exactly from the to_at-th ram_en cycle on.
   // mut_at > 0: requester inputs are disturbed in that ram_en cycle.
   // drop: 0 keep requests, 1 drop owner's request at ack, 2 drop both.
   task automatic serve(input int lat, input int to_at, input int mut_at,
                        input int drop, input bit chk_gap);
      txn_t e;
      int   n;
      int   grant_edge;
      bit   seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ram_en === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL grant_wait: ram_en=%b after 20 cycles, required 1", ram_en);
         return;
      end
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL unexpected_grant: addr=%h with empty scoreboard, required no grant", ram_addr);
         return;
      end
      e = sb.pop_front();
      grant_edge = cyc;
      if (chk_gap) begin
         checks++;
         if (grant_edge - last_rdy_edge !== 3) begin
            failures++;
            $display("FAIL grant_gap: %0d cycles after ram_rdy, required 3", grant_edge - last_rdy_edge);
         end
      end
      if (e.wr) begin
         checks++;
         if (data_to_ram !== e.wdata) begin
            failures++;
            $display("FAIL data_to_ram: got %h required %h", data_to_ram, e.wdata);
         end
      end
      n = 1;
      forever begin
         checks++;
         if (ram_en !== 1'b1) begin
            failures++;
            $display("FAIL ram_en_hold: cycle %0d got %b required 1", n, ram_en);
         end
         checks++;
         if (ram_addr !== e.addr) begin
            failures++;
            $display("FAIL ram_addr: cycle %0d got %h required %h", n, ram_addr, e.addr);
         end
         checks++;
         if (ram_write !== e.wr) begin
            failures++;
            $display("FAIL ram_write: cycle %0d got %b required %b", n, ram_write, e.wr);
         end
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy: cycle %0d got %b required 1", n, busy);
         end
         if (to_at > 0) begin
            checks++;
            if (timeout_err !== (n >= to_at)) begin
               failures++;
               $display("FAIL timeout_err: cycle %0d got %b required %b", n, timeout_err, (n >= to_at));
            end
         end
         if (n == mut_at) begin
            dc_addr  = dc_addr + 30'h10;
            dc_write = ~dc_write;
            dc_wdata = ~dc_wdata;
            ic_addr  = ic_addr + 30'h10;
         end
         if (n >= lat) break;
         @(negedge clk);
         n++;
      end
      ram_rdy        = 1'b1;
      block_from_ram = e.blk;
      last_rdy_edge  = cyc + 1;
      @(negedge clk);
      ram_rdy        = 1'b0;
      block_from_ram = rand256();
      if (!e.wr) model_rdata = e.blk;
      checks++;
      if (dc_ack !== e.is_dc) begin
         failures++;
         $display("FAIL dc_ack: got %b required %b", dc_ack, e.is_dc);
      end
      checks++;
      if (ic_ack !== !e.is_dc) begin
         failures++;
         $display("FAIL ic_ack: got %b required %b", ic_ack, !e.is_dc);
      end
      checks++;
      if (ram_en !== 1'b0) begin
         failures++;
         $display("FAIL ram_en_ack: got %b required 0", ram_en);
      end
      checks++;
      if (rdata !== model_rdata) begin
         failures++;
         $display("FAIL rdata: got %h required %h", rdata, model_rdata);
      end
      if (drop == 1) begin
         if (e.is_dc) dc_req = 1'b0;
         else ic_req = 1'b0;
      end else if (drop == 2) begin
         dc_req = 1'b0;
         ic_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ((ic_ack | dc_ack) !== 1'b0) begin
         failures++;
         $display("FAIL ack_width: ic_ack=%b dc_ack=%b required 0 0", ic_ack, dc_ack);
      end
      checks++;
      if (ram_en !== 1'b0) begin
         failures++;
         $display("FAIL ram_en_gap: got %b required 0", ram_en);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({ram_en, ram_write, ic_ack, dc_ack, busy, timeout_err} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: en/wr/ica/dca/busy/to=%b required 000000",
                  {ram_en, ram_write, ic_ack, dc_ack, busy, timeout_err});
      end
      checks++;
      if (ram_addr !== 30'h0) begin
         failures++;
         $display("FAIL reset_addr: got %h required 0", ram_addr);
      end
      checks++;
      if ((data_to_ram | rdata) !== 256'h0) begin
         failures++;
         $display("FAIL reset_data: data_to_ram=%h rdata=%h required 0", data_to_ram, rdata);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, ram_en} !== 2'b00) begin
         failures++;
         $display("FAIL idle_after_reset: busy/ram_en=%b required 00", {busy, ram_en});
      end
   endtask

   task automatic test_ic_read();
      ic_addr = 30'h100;
      ic_req  = 1'b1;
      sb.push_back(mk(1'b0, 1'b0, 30'h100, 256'h0, {8{32'hA5A5A5A5}}));
      serve(5, 100, 0, 1, 1'b0);
      checks++;
      if (rdata !== {8{32'hA5A5A5A5}}) begin
         failures++;
         $display("FAIL ic_rdata: got %h required A5..A5", rdata);
      end
   endtask

   task automatic test_dc_write();
      dc_write = 1'b1;
      dc_addr  = 30'h2000;
      dc_wdata = 256'h1234;
      dc_req   = 1'b1;
      sb.push_back(mk(1'b1, 1'b1, 30'h2000, 256'h1234, rand256()));
      serve(3, 100, 0, 1, 1'b0);
      dc_write = 1'b0;
   endtask

   task automatic test_stability();
      dc_write = 1'b0;
      dc_addr  = 30'h10;
      dc_req   = 1'b1;
      sb.push_back(mk(1'b1, 1'b0, 30'h10, 256'h0, rand256()));
      serve(4, 100, 2, 1, 1'b0);
      dc_write = 1'b0;
   endtask

   task automatic test_contention();
      logic [255:0] b[4];
      for (int i = 0; i < 4; i++) b[i] = rand256();
      rst = 1'b1;
      @(negedge clk);
      ic_addr  = 30'h300;
      dc_addr  = 30'h400;
      dc_write = 1'b0;
      ic_req   = 1'b1;
      dc_req   = 1'b1;
      model_rdata = '0;
      @(negedge clk);
      rst = 1'b0;
      sb.push_back(mk(1'b1, 1'b0, 30'h400, 256'h0, b[0]));
      sb.push_back(mk(1'b0, 1'b0, 30'h300, 256'h0, b[1]));
      sb.push_back(mk(1'b1, 1'b0, 30'h400, 256'h0, b[2]));
      sb.push_back(mk(1'b0, 1'b0, 30'h300, 256'h0, b[3]));
      serve(2, 100, 0, 0, 1'b0);
      serve(2, 100, 0, 0, 1'b1);
      serve(3, 100, 0, 0, 1'b1);
      serve(2, 100, 0, 2, 1'b1);
   endtask

   task automatic test_watchdog();
      dc_write = 1'b0;
      dc_addr  = 30'h55;
      dc_req   = 1'b1;
      sb.push_back(mk(1'b1, 1'b0, 30'h55, 256'h0, rand256()));
      serve(12, 9, 0, 1, 1'b0);
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_sticky: got %b required 1", timeout_err);
      end
   endtask

   task automatic test_reset_mid_busy();
      bit seen;
      seen = 1'b0;
      dc_addr = 30'h77;
      dc_req  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ram_en === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL rst_grant_wait: ram_en=%b required 1", ram_en);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ram_en, ic_ack, dc_ack, busy, timeout_err} !== 5'b0) begin
         failures++;
         $display("FAIL async_reset: en/ica/dca/busy/to=%b required 00000",
                  {ram_en, ic_ack, dc_ack, busy, timeout_err});
      end
      model_rdata = '0;
      @(negedge clk);
      dc_req = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, ram_en} !== 2'b00) begin
         failures++;
         $display("FAIL idle_after_rst: busy/ram_en=%b required 00", {busy, ram_en});
      end
      ic_addr = 30'h3;
      ic_req  = 1'b1;
      sb.push_back(mk(1'b0, 1'b0, 30'h3, 256'h0, rand256()));
      serve(1, 100, 0, 1, 1'b0);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_ic_read();
      test_dc_write();
      test_stability();
      test_contention();
      test_watchdog();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
